// File: rtl/chi_row_stage_if.sv
// Handshake bundle for chi_row_stage: lane input stream, result output stream and done pulse.
// The rc round-constant signal exists only when CHI_IOTA_EN is defined.
`timescale 1ns/1ps
interface chi_row_stage_if #(
  parameter int LANE_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [LANE_W-1:0] in_lane;
  logic              out_valid;
  logic              out_ready;
  logic [LANE_W-1:0] out_lane;
  logic [4:0]        out_idx;
  logic              done;
`ifdef CHI_IOTA_EN
  logic [LANE_W-1:0] rc;
`endif

  modport master (
`ifdef CHI_IOTA_EN
    output rc,
`endif
    output in_valid, in_lane, out_ready,
    input  in_ready, out_valid, out_lane, out_idx, done
  );

  modport slave (
`ifdef CHI_IOTA_EN
    input  rc,
`endif
    input  in_valid, in_lane, out_ready,
    output in_ready, out_valid, out_lane, out_idx, done
  );
endinterface

// File: rtl/chi_row_stage.sv
// Chi step over a stream of permuted lanes: buffers one 5-lane row, then emits its chi results.
// Optional iota folding of rc into lane 0 is enabled by defining CHI_IOTA_EN.
`timescale 1ns/1ps
module chi_row_stage #(
  parameter int LANE_W   = 64,
  parameter int NUM_ROWS = 5
) (
  input logic            clk,
  input logic            rst,
  chi_row_stage_if.slave bus
);
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [1:0] {LOAD, EMIT, FIN} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [2:0]        r_xCnt;
  logic [ROW_W-1:0]  r_rowCnt;
  logic [LANE_W-1:0] r_buf [5];
  logic [LANE_W-1:0] w_chiAll [5];
  logic [LANE_W-1:0] w_lane;
  logic [4:0]        w_idx;
  logic              w_inReady;
  logic              w_outValid;
  logic              w_done;
  logic              w_lastX;
  logic              w_lastRow;

  assign w_lastX   = (r_xCnt == 3'd4);
  assign w_lastRow = (r_rowCnt == ROW_W'(NUM_ROWS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_inReady  = 1'b0;
    w_outValid = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      LOAD: begin
        w_inReady = 1'b1;
        if (bus.in_valid && w_lastX) w_next = EMIT;
      end
      EMIT: begin
        w_outValid = 1'b1;
        if (bus.out_ready && w_lastX) w_next = w_lastRow ? FIN : LOAD;
      end
      FIN: begin
        w_done = 1'b1;
        w_next = LOAD;
      end
      default: w_next = LOAD;
    endcase
  end

  // The buffer is written only in LOAD, so chi in EMIT always sees the complete original row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xCnt   <= '0;
      r_rowCnt <= '0;
      for (int i = 0; i < 5; i++) r_buf[i] <= '0;
    end else begin
      case (r_state)
        LOAD: begin
          if (bus.in_valid) begin
            for (int i = 0; i < 5; i++)
              if (r_xCnt == 3'(i)) r_buf[i] <= bus.in_lane;
            r_xCnt <= w_lastX ? 3'd0 : r_xCnt + 3'd1;
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            if (w_lastX) begin
              r_xCnt <= 3'd0;
              if (!w_lastRow) r_rowCnt <= r_rowCnt + ROW_W'(1);
            end else begin
              r_xCnt <= r_xCnt + 3'd1;
            end
          end
        end
        FIN: begin
          r_xCnt   <= 3'd0;
          r_rowCnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 5; i++)
      w_chiAll[i] = r_buf[i] ^ (~r_buf[(i + 1) % 5] & r_buf[(i + 2) % 5]);
  end

  assign w_idx = w_outValid ? (5'(r_rowCnt) * 5'd5 + 5'(r_xCnt)) : 5'd0;

  always_comb begin
    w_lane = '0;
    for (int i = 0; i < 5; i++)
      if (r_xCnt == 3'(i)) w_lane = w_chiAll[i];
`ifdef CHI_IOTA_EN
    if (w_idx == 5'd0) w_lane = w_lane ^ bus.rc;
`endif
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign bus.out_lane  = w_outValid ? w_lane : '0;
  assign bus.out_idx   = w_idx;
  assign bus.done      = w_done;
endmodule

// File: tb/tb_chi_row_stage.sv
// Directed self-checking bench for chi_row_stage: reset, streaming, chi values, backpressure,
// mid-state reset; lane 0 expectations include rc when CHI_IOTA_EN is defined.
`timescale 1ns/1ps
module tb_chi_row_stage;
  localparam int          LANE_W = 64;
  localparam logic [63:0] RC     = 64'h0000_0000_0000_8082;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  int   checks  = 0;
  int   errors  = 0;
  int   posCnt  = 0;
  int   doneCnt = 0;
  int   startCnt;
  int   doneBefore;

  logic [63:0] rowIn  [5] = '{64'd1, 64'd2, 64'd4, 64'd8, 64'd16};
  logic [63:0] rowExp [5] = '{64'd5, 64'd10, 64'd20, 64'd9, 64'd18};

  chi_row_stage_if #(.LANE_W(LANE_W)) bus ();

  chi_row_stage #(.LANE_W(LANE_W), .NUM_ROWS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Counted on posedge so the negedge sampling in the main sequence never races it.
  always @(posedge clk) begin
    posCnt++;
    if (bus.done) doneCnt++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic logic [63:0] iota(input logic [4:0] idx, input logic [63:0] v);
    logic [63:0] rcTerm;
`ifdef CHI_IOTA_EN
    rcTerm = RC;
`else
    rcTerm = '0;
`endif
    return (idx == 5'd0) ? (v ^ rcTerm) : v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    checkOutput({tag, "_out_lane"},  bus.out_lane,       64'd0);
    checkOutput({tag, "_out_idx"},   64'(bus.out_idx),   64'd0);
    checkOutput({tag, "_done"},      64'(bus.done),      64'd0);
  endtask

  // Called at a negedge; presents one lane and returns at the negedge after the transfer.
  task automatic applyStimulus(input logic [63:0] lane);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready_wait", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_lane  = lane;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Called at a negedge with out_ready high; checks the presented lane, then lets it transfer.
  task automatic popLane(input string tag, input logic [63:0] expLane, input logic [4:0] expIdx);
    int n = 0;
    while (bus.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    checkOutput({tag, "_lane"}, bus.out_lane, expLane);
    checkOutput({tag, "_idx"}, 64'(bus.out_idx), 64'(expIdx));
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_lane   = '0;
    bus.out_ready = 1'b1;
`ifdef CHI_IOTA_EN
    bus.rc        = RC;
`endif
    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Test 1: all-zero state; done must appear in the 51st cycle counting the first accept cycle.
    startCnt   = posCnt;
    doneBefore = doneCnt;
    for (int r = 0; r < 5; r++) begin
      for (int x = 0; x < 5; x++) applyStimulus(64'd0);
      for (int x = 0; x < 5; x++) popLane("t1", iota(5'(5 * r + x), 64'd0), 5'(5 * r + x));
    end
    checkOutput("t1_done_high", 64'(bus.done), 64'd1);
    checkOutput("t1_done_cycle", 64'(posCnt - startCnt + 1), 64'd51);
    @(negedge clk);
    checkOutput("t1_done_low", 64'(bus.done), 64'd0);
    checkOutput("t1_done_count", 64'(doneCnt - doneBefore), 64'd1);

    // Tests 2 and 3: single-bit row, then all-ones rows which chi leaves unchanged.
    for (int x = 0; x < 5; x++) applyStimulus(rowIn[x]);
    for (int x = 0; x < 5; x++) popLane("t2", iota(5'(x), rowExp[x]), 5'(x));
    for (int r = 1; r < 5; r++) begin
      for (int x = 0; x < 5; x++) applyStimulus(ONES);
      for (int x = 0; x < 5; x++) popLane("t3", ONES, 5'(5 * r + x));
    end
    checkOutput("t3_done_high", 64'(bus.done), 64'd1);
    @(negedge clk);

    // Test 4: stall at x=2 for 7 cycles while offering a junk lane that must be ignored.
    for (int x = 0; x < 5; x++) applyStimulus(rowIn[x]);
    popLane("t4", iota(5'd0, rowExp[0]), 5'd0);
    popLane("t4", rowExp[1], 5'd1);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_lane   = 64'hDEAD_BEEF_0BAD_F00D;
    repeat (7) begin
      checkOutput("t4_stall_lane", bus.out_lane, 64'd20);
      checkOutput("t4_stall_idx", 64'(bus.out_idx), 64'd2);
      checkOutput("t4_stall_in_ready", 64'(bus.in_ready), 64'd0);
      checkOutput("t4_stall_out_valid", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int x = 2; x < 5; x++) popLane("t4_resume", rowExp[x], 5'(x));
    for (int x = 0; x < 5; x++) applyStimulus(rowIn[x]);
    for (int x = 0; x < 5; x++) popLane("t4_row1", rowExp[x], 5'(5 + x));

    // Test 5: reset after 3 lanes of row 2; partial row dropped, next lane restarts at k=0.
    doneBefore = doneCnt;
    for (int x = 0; x < 3; x++) applyStimulus(64'hA5A5_0000_0000_0001 << x);
    rst = 1'b1;
    #1;
    checkResetOutputs("t5_in_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("t5_after_reset");
    for (int x = 0; x < 5; x++) applyStimulus(rowIn[x]);
    for (int x = 0; x < 5; x++) popLane("t5", iota(5'(x), rowExp[x]), 5'(x));
    checkOutput("t5_no_done", 64'(doneCnt - doneBefore), 64'd0);
    checkOutput("t5_back_to_load", 64'(bus.in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
